axi_stream_extract_header: RTL and testbench

// - Receive-side counterpart of the header inserter: sits downstream of a link carrying header+payload packets.
// - Removes the leading hdr_bytes bytes of each packet and presents them on a header side channel.
// - Re-packs the remaining payload bytes MSB-contiguous onto an AXI-Stream output, so only the last beat is partial.

---
 rtl/axis_stream_pkg.sv | 36 +++
 rtl/axis_out_slice.sv | 52 +++++
 rtl/axi_stream_extract_header.sv | 225 ++++++++++++++++++++++
 tb/tb_axi_stream_extract_header.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_stream_pkg.sv
// Shared helpers for the AXI-Stream header extractor: byte-lane constants,
// keep-mask utilities and the extractor FSM state type.
package axis_stream_pkg;

  // Widest bus the keep helpers support (512-bit data, 64 byte lanes).
  localparam int MAX_BYTES = 64;
  localparam int BYTE_WD   = 8;

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    FLUSH
  } state_e;

  // Number of set bits in a (zero-extended) keep vector.
  function automatic int popcount_keep(input logic [MAX_BYTES-1:0] keep);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (keep[i]) cnt++;
    end
    return cnt;
  endfunction

  // MSB-contiguous mask of 'cnt' ones inside an 'nb'-lane keep vector;
  // the caller slices the low nb bits off the result.
  function automatic logic [MAX_BYTES-1:0] keep_from_cnt(input int cnt, input int nb);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i < nb) && (i >= nb - cnt);
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_out_slice.sv
// One-entry AXI-Stream output register. The owner only loads it when
// free_o is high, so a held beat is never overwritten before its handshake.
module axis_out_slice #(
  parameter int DATA_WD = 32,
  parameter int KEEP_WD = DATA_WD / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DATA_WD-1:0] data_i,
  input  logic [KEEP_WD-1:0] keep_i,
  input  logic               last_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [DATA_WD-1:0] data_o,
  output logic [KEEP_WD-1:0] keep_o,
  output logic               last_o,
  output logic               free_o
);

  logic               valid_q;
  logic [DATA_WD-1:0] data_q;
  logic [KEEP_WD-1:0] keep_q;
  logic               last_q;

  // Hold the beat until the sink takes it; a new load replaces a draining beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // The register can accept a new beat when empty or emptying this cycle.
  always_comb begin
    free_o  = !valid_q || ready_i;
    valid_o = valid_q;
    data_o  = data_q;
    keep_o  = keep_q;
    last_o  = last_q;
  end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips the leading hdr_bytes bytes of every packet onto a header side
// channel and re-packs the remaining payload MSB-contiguous, so only the
// final payload beat can be partial.
module axi_stream_extract_header
  import axis_stream_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic [BYTE_CNT_WD:0]    hdr_bytes,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    hdr_err
);

  localparam int CNT_WD = BYTE_CNT_WD + 1;

  // Expand a keep vector into a per-bit data mask.
  function automatic logic [DATA_WD-1:0] byteMask(input logic [DATA_BYTE_WD-1:0] keep);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      m[i*BYTE_WD +: BYTE_WD] = {BYTE_WD{keep[i]}};
    end
    return m;
  endfunction

  // MSB-contiguous keep of 'cnt' lanes for this bus width.
  function automatic logic [DATA_BYTE_WD-1:0] keepN(input int cnt);
    logic [MAX_BYTES-1:0] m;
    m = keep_from_cnt(cnt, DATA_BYTE_WD);
    return m[DATA_BYTE_WD-1:0];
  endfunction

  state_e                    state_q, state_d;
  logic [DATA_WD-1:0]        resid_q, resid_d;
  logic [CNT_WD-1:0]         residCnt_q, residCnt_d;
  logic                      hdrLoaded_q;

  logic                      accept;
  logic                      payFree, hdrFree;
  logic [DATA_WD-1:0]        beatMasked;
  logic [DATA_WD-1:0]        firstPay;
  logic [2*DATA_WD-1:0]      bodyWide;
  int                        kCnt, sCnt, hdrCnt, bodyTotal;

  logic                      payLoad, payLast;
  logic [DATA_WD-1:0]        payData;
  logic [DATA_BYTE_WD-1:0]   payKeep;
  logic                      hdrLoad, hdrShort, hdrShortOut;
  logic [DATA_WD-1:0]        hdrData;
  logic [DATA_BYTE_WD-1:0]   hdrKeep;

  assign ready_in = (state_q != FLUSH) && payFree && ((state_q != IDLE) || hdrFree);
  assign accept   = valid_in && ready_in;
  assign hdr_err  = hdrLoaded_q && hdrShortOut;

  // Byte-lane arithmetic: first-beat split and residual ++ beat concatenation.
  always_comb begin
    beatMasked = data_in & byteMask(keep_in);
    kCnt       = popcount_keep(MAX_BYTES'(keep_in));
    sCnt       = int'(hdr_bytes);
    hdrCnt     = (kCnt < sCnt) ? kCnt : sCnt;
    firstPay   = beatMasked << (BYTE_WD * sCnt);
    bodyWide   = {resid_q, {DATA_WD{1'b0}}} |
                 ({beatMasked, {DATA_WD{1'b0}}} >> (BYTE_WD * int'(residCnt_q)));
    bodyTotal  = int'(residCnt_q) + kCnt;
  end

  // State, residual buffer and error-pulse qualifier registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      resid_q     <= '0;
      residCnt_q  <= '0;
      hdrLoaded_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      resid_q     <= resid_d;
      residCnt_q  <= residCnt_d;
      hdrLoaded_q <= hdrLoad;
    end
  end

  // Next state and next residual contents.
  always_comb begin
    state_d    = state_q;
    resid_d    = resid_q;
    residCnt_d = residCnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (last_in) begin
            residCnt_d = '0;
          end else begin
            state_d    = BODY;
            resid_d    = firstPay;
            residCnt_d = (kCnt > sCnt) ? CNT_WD'(kCnt - sCnt) : '0;
          end
        end
      end
      BODY: begin
        if (accept) begin
          if (bodyTotal >= DATA_BYTE_WD) begin
            resid_d    = bodyWide[DATA_WD-1:0];
            residCnt_d = CNT_WD'(bodyTotal - DATA_BYTE_WD);
            if (last_in) state_d = (bodyTotal > DATA_BYTE_WD) ? FLUSH : IDLE;
          end else if (last_in) begin
            state_d    = IDLE;
            residCnt_d = '0;
          end else begin
            resid_d    = bodyWide[2*DATA_WD-1 -: DATA_WD];
            residCnt_d = CNT_WD'(bodyTotal);
          end
        end
      end
      FLUSH: begin
        if (payFree) begin
          state_d    = IDLE;
          residCnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Loads for the header and payload output registers.
  always_comb begin
    payLoad  = 1'b0;
    payData  = '0;
    payKeep  = '0;
    payLast  = 1'b0;
    hdrLoad  = 1'b0;
    hdrData  = '0;
    hdrKeep  = '0;
    hdrShort = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          hdrLoad  = 1'b1;
          hdrKeep  = keepN(hdrCnt);
          hdrData  = beatMasked & byteMask(hdrKeep);
          hdrShort = (kCnt < sCnt);
          if (last_in && (kCnt > sCnt)) begin
            payLoad = 1'b1;
            payData = firstPay;
            payKeep = keepN(kCnt - sCnt);
            payLast = 1'b1;
          end
        end
      end
      BODY: begin
        if (accept) begin
          if (bodyTotal >= DATA_BYTE_WD) begin
            payLoad = 1'b1;
            payData = bodyWide[2*DATA_WD-1 -: DATA_WD];
            payKeep = '1;
            payLast = last_in && (bodyTotal == DATA_BYTE_WD);
          end else if (last_in && (bodyTotal > 0)) begin
            payLoad = 1'b1;
            payData = bodyWide[2*DATA_WD-1 -: DATA_WD];
            payKeep = keepN(bodyTotal);
            payLast = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (payFree) begin
          payLoad = 1'b1;
          payData = resid_q;
          payKeep = keepN(int'(residCnt_q));
          payLast = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The header register's last bit carries the short-header flag so the
  // error pulse lines up with the header word it belongs to.
  axis_out_slice #(.DATA_WD(DATA_WD), .KEEP_WD(DATA_BYTE_WD)) uHdrSlice (
    .clk     (clk),
    .rst     (rst),
    .load_i  (hdrLoad),
    .data_i  (hdrData),
    .keep_i  (hdrKeep),
    .last_i  (hdrShort),
    .ready_i (ready_hdr),
    .valid_o (valid_hdr),
    .data_o  (data_hdr),
    .keep_o  (keep_hdr),
    .last_o  (hdrShortOut),
    .free_o  (hdrFree)
  );

  axis_out_slice #(.DATA_WD(DATA_WD), .KEEP_WD(DATA_BYTE_WD)) uPaySlice (
    .clk     (clk),
    .rst     (rst),
    .load_i  (payLoad),
    .data_i  (payData),
    .keep_i  (payKeep),
    .last_i  (payLast),
    .ready_i (ready_out),
    .valid_o (valid_out),
    .data_o  (data_out),
    .keep_o  (keep_out),
    .last_o  (last_out),
    .free_o  (payFree)
  );

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Self-checking bench for axi_stream_extract_header with a packet-level
// byte-queue model of header extraction and payload re-packing.
module tb_axi_stream_extract_header;

  localparam int NB = 4;
  localparam int DW = 32;
  localparam int CW = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in, last_in, ready_in;
  logic [DW-1:0] data_in;
  logic [NB-1:0] keep_in;
  logic [CW-1:0] hdr_bytes;
  logic          valid_hdr, ready_hdr;
  logic [DW-1:0] data_hdr;
  logic [NB-1:0] keep_hdr;
  logic          valid_out, last_out, ready_out;
  logic [DW-1:0] data_out;
  logic [NB-1:0] keep_out;
  logic          hdr_err;

  axi_stream_extract_header #(.DATA_WD(DW)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in), .hdr_bytes(hdr_bytes),
    .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out), .hdr_err(hdr_err)
  );

  initial forever #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  int          errSeen = 0;
  int          expErr = 0;
  int          stallCount = 0;
  bit          randReady = 0;
  logic [7:0]  pkt[$];
  beat_t       expPay[$], expHdr[$], payLog[$], hdrLog[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkBeat(input string name, input beat_t b, input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
    checkOutput({name, "_data"}, 64'(b.data), 64'(d));
    checkOutput({name, "_keep"}, 64'(b.keep), 64'(k));
    checkOutput({name, "_last"}, 64'(b.last), 64'(l));
  endtask

  function automatic logic [NB-1:0] keepOf(input int n);
    logic [NB-1:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k[NB-1-i] = 1'b1;
    return k;
  endfunction

  // Reference model: header = first min(S, first-beat length) bytes,
  // payload = every byte after the header, cut into NB-byte beats.
  task automatic modelPacket(input int s);
    int    firstLen, hn, idx, n;
    beat_t h, b;
    firstLen = (pkt.size() < NB) ? pkt.size() : NB;
    hn = (s < firstLen) ? s : firstLen;
    h.data = '0;
    for (int j = 0; j < hn; j++) h.data[DW-1-8*j -: 8] = pkt[j];
    h.keep = keepOf(hn);
    h.last = 1'b0;
    expHdr.push_back(h);
    if (s > firstLen) expErr++;
    idx = hn;
    while (idx < pkt.size()) begin
      n = ((pkt.size() - idx) < NB) ? (pkt.size() - idx) : NB;
      b.data = '0;
      for (int j = 0; j < n; j++) b.data[DW-1-8*j -: 8] = pkt[idx+j];
      b.keep = keepOf(n);
      b.last = (idx + n >= pkt.size());
      expPay.push_back(b);
      idx += n;
    end
  endtask

  // Drive up to maxBeats beats of pkt; must be called at posedge+1.
  task automatic applyStimulus(input int s, input int maxBeats, input int gapPct);
    int  nBeats, idx, n, waited;
    bit  hs;
    nBeats = (pkt.size() + NB - 1) / NB;
    if (maxBeats < nBeats) nBeats = maxBeats;
    stallCount = 0;
    for (int b = 0; b < nBeats; b++) begin
      if ($urandom_range(0, 99) < gapPct) begin
        valid_in = 1'b0;
        @(posedge clk); #1;
      end
      idx = b * NB;
      n = ((pkt.size() - idx) < NB) ? (pkt.size() - idx) : NB;
      for (int j = 0; j < NB; j++)
        data_in[DW-1-8*j -: 8] = (j < n) ? pkt[idx+j] : 8'($urandom);
      keep_in   = keepOf(n);
      last_in   = (idx + n >= pkt.size());
      hdr_bytes = (b == 0) ? CW'(s) : CW'($urandom_range(1, NB));
      valid_in  = 1'b1;
      waited = 0;
      forever begin
        @(negedge clk);
        hs = ready_in;
        @(posedge clk); #1;
        if (hs) break;
        stallCount++;
        waited++;
        if (waited > 1000) begin
          checks++; fails++;
          $display("[TB] FAIL input_accept_timeout: beat %0d not accepted, expected accept", b);
          valid_in = 1'b0;
          return;
        end
      end
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expPay.size() != 0 || expHdr.size() != 0) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    if (expPay.size() != 0 || expHdr.size() != 0) begin
      checks++; fails++;
      $display("[TB] FAIL drain_timeout: %0d payload / %0d header beats outstanding, expected 0", expPay.size(), expHdr.size());
    end
    @(posedge clk); #1;
  endtask

  // Compare process: checks every handshake and hold-while-stalled.
  initial begin
    beat_t prevP, prevH, e, cur;
    bit    stallP, stallH;
    stallP = 0; stallH = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stallP = 0; stallH = 0;
        continue;
      end
      if (stallP) begin
        checkOutput("pay_hold_valid", 64'(valid_out), 64'd1);
        checkOutput("pay_hold_data", 64'(data_out), 64'(prevP.data));
        checkOutput("pay_hold_keep", 64'(keep_out), 64'(prevP.keep));
        checkOutput("pay_hold_last", 64'(last_out), 64'(prevP.last));
      end
      cur.data = data_out; cur.keep = keep_out; cur.last = last_out;
      if (valid_out && ready_out) begin
        payLog.push_back(cur);
        if (expPay.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL pay_unexpected: got beat 0x%0h, expected none", data_out);
        end else begin
          e = expPay.pop_front();
          checkBeat("pay", cur, e.data, e.keep, e.last);
        end
      end
      stallP = valid_out && !ready_out;
      prevP = cur;

      if (stallH) begin
        checkOutput("hdr_hold_valid", 64'(valid_hdr), 64'd1);
        checkOutput("hdr_hold_data", 64'(data_hdr), 64'(prevH.data));
        checkOutput("hdr_hold_keep", 64'(keep_hdr), 64'(prevH.keep));
      end
      cur.data = data_hdr; cur.keep = keep_hdr; cur.last = 1'b0;
      if (valid_hdr && ready_hdr) begin
        hdrLog.push_back(cur);
        if (expHdr.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL hdr_unexpected: got header 0x%0h, expected none", data_hdr);
        end else begin
          e = expHdr.pop_front();
          checkOutput("hdr_data", 64'(data_hdr), 64'(e.data));
          checkOutput("hdr_keep", 64'(keep_hdr), 64'(e.keep));
        end
      end
      stallH = valid_hdr && !ready_hdr;
      prevH = cur;
      if (hdr_err) errSeen++;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (randReady) begin
      ready_out = 1'($urandom_range(0, 1));
      ready_hdr = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid_out"}, 64'(valid_out), 64'd0);
    checkOutput({tag, "_data_out"}, 64'(data_out), 64'd0);
    checkOutput({tag, "_keep_out"}, 64'(keep_out), 64'd0);
    checkOutput({tag, "_last_out"}, 64'(last_out), 64'd0);
    checkOutput({tag, "_valid_hdr"}, 64'(valid_hdr), 64'd0);
    checkOutput({tag, "_data_hdr"}, 64'(data_hdr), 64'd0);
    checkOutput({tag, "_keep_hdr"}, 64'(keep_hdr), 64'd0);
    checkOutput({tag, "_hdr_err"}, 64'(hdr_err), 64'd0);
    checkOutput({tag, "_ready_in"}, 64'(ready_in), 64'd1);
  endtask

  initial begin
    int errBase, nExp, s, nb, lastK;
    rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    hdr_bytes = 3'd1; ready_out = 1'b1; ready_hdr = 1'b1;
    #1;
    checkResetOutputs("reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Directed 1: S=2 across three beats.
    payLog.delete(); hdrLog.delete();
    pkt = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    modelPacket(2);
    applyStimulus(2, 100, 0);
    waitDrain();
    checkOutput("t1_pay_beats", 64'(payLog.size()), 64'd2);
    checkOutput("t1_hdr_words", 64'(hdrLog.size()), 64'd1);
    if (hdrLog.size() == 1) checkBeat("t1_hdr", hdrLog[0], 32'hAABB0000, 4'hC, 1'b0);
    if (payLog.size() == 2) begin
      checkBeat("t1_pay0", payLog[0], 32'h01020304, 4'hF, 1'b0);
      checkBeat("t1_pay1", payLog[1], 32'h05060708, 4'hF, 1'b1);
    end

    // Directed 2: S=3 needs a flush beat.
    payLog.delete(); hdrLog.delete();
    pkt = '{8'hA1, 8'hA2, 8'hA3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    modelPacket(3);
    applyStimulus(3, 100, 0);
    checkOutput("t2_flush_ready_in", 64'(ready_in), 64'd0);
    @(posedge clk); #1;
    checkOutput("t2_ready_after_flush", 64'(ready_in), 64'd1);
    waitDrain();
    checkOutput("t2_pay_beats", 64'(payLog.size()), 64'd2);
    if (hdrLog.size() == 1) checkBeat("t2_hdr", hdrLog[0], 32'hA1A2A300, 4'hE, 1'b0);
    if (payLog.size() == 2) begin
      checkBeat("t2_pay0", payLog[0], 32'h01020304, 4'hF, 1'b0);
      checkBeat("t2_pay1", payLog[1], 32'h05000000, 4'h8, 1'b1);
    end

    // Directed 3: S=4 pass-through.
    payLog.delete(); hdrLog.delete();
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
            8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    modelPacket(4);
    applyStimulus(4, 100, 0);
    waitDrain();
    checkOutput("t3_pay_beats", 64'(payLog.size()), 64'd3);
    if (hdrLog.size() == 1) checkBeat("t3_hdr", hdrLog[0], 32'h11223344, 4'hF, 1'b0);
    if (payLog.size() == 3) begin
      checkBeat("t3_pay0", payLog[0], 32'h55667788, 4'hF, 1'b0);
      checkBeat("t3_pay1", payLog[1], 32'h99AABBCC, 4'hF, 1'b0);
      checkBeat("t3_pay2", payLog[2], 32'hDD000000, 4'h8, 1'b1);
    end

    // Directed 4: single-beat packets, exact header and short header.
    payLog.delete(); hdrLog.delete();
    errBase = errSeen;
    pkt = '{8'hC1, 8'hC2};
    modelPacket(2);
    applyStimulus(2, 100, 0);
    waitDrain();
    checkOutput("t4a_pay_beats", 64'(payLog.size()), 64'd0);
    checkOutput("t4a_err_pulses", 64'(errSeen - errBase), 64'd0);
    if (hdrLog.size() == 1) checkBeat("t4a_hdr", hdrLog[0], 32'hC1C20000, 4'hC, 1'b0);
    hdrLog.delete();
    errBase = errSeen;
    pkt = '{8'hD1};
    modelPacket(2);
    applyStimulus(2, 100, 0);
    waitDrain();
    checkOutput("t4b_pay_beats", 64'(payLog.size()), 64'd0);
    checkOutput("t4b_err_pulses", 64'(errSeen - errBase), 64'd1);
    if (hdrLog.size() == 1) checkBeat("t4b_hdr", hdrLog[0], 32'hD1000000, 4'h8, 1'b0);

    // Throughput: 7 full beats with both sinks ready must never stall.
    pkt.delete();
    for (int i = 0; i < 28; i++) pkt.push_back(8'($urandom));
    modelPacket(4);
    applyStimulus(4, 100, 0);
    checkOutput("throughput_stalls", 64'(stallCount), 64'd0);
    waitDrain();

    // Randomized packets with random backpressure and input gaps.
    errBase = errSeen;
    nExp = expErr;
    randReady = 1;
    for (int p = 0; p < 200; p++) begin
      s = $urandom_range(1, NB);
      nb = $urandom_range(1, 4);
      lastK = $urandom_range(1, NB);
      pkt.delete();
      for (int i = 0; i < NB * (nb - 1) + lastK; i++) pkt.push_back(8'($urandom));
      modelPacket(s);
      applyStimulus(s, 100, 20);
    end
    waitDrain();
    checkOutput("random_err_pulses", 64'(errSeen - errBase), 64'(expErr - nExp));
    randReady = 0;
    @(posedge clk); #1;
    ready_out = 1'b1; ready_hdr = 1'b1;
    @(posedge clk); #1;

    // Reset mid-BODY drops the packet; the next packet still extracts cleanly.
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back(8'($urandom));
    modelPacket(2);
    applyStimulus(2, 2, 0);
    #1 rst = 1'b1;
    #1;
    checkResetOutputs("midrst");
    expPay.delete(); expHdr.delete();
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    payLog.delete();
    pkt.delete();
    for (int i = 0; i < 11; i++) pkt.push_back(8'($urandom));
    modelPacket(3);
    checkOutput("model_recovery_beats", 64'(expPay.size()), 64'd2);
    applyStimulus(3, 100, 0);
    waitDrain();
    checkOutput("recovery_pay_beats", 64'(payLog.size()), 64'd2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
